// File: rtl/menu_pkg.sv
// Shared types and helpers for the top-menu bar: FSM states, palette and box placement.
package menu_pkg;

    typedef enum logic {
        ST_BROWSE  = 1'b0,
        ST_CONFIRM = 1'b1
    } state_t;

    localparam logic [2:0] COL_SEP     = 3'b000;
    localparam logic [2:0] COL_BROWSE  = 3'b100;
    localparam logic [2:0] COL_CONFIRM = 3'b010;
    localparam logic [2:0] COL_OFF     = 3'b000;

    // Left x of box idx; boxes from split_idx onward are shifted by the extra split gap.
    function automatic int item_left(input int idx, input int item_w, input int item_gap,
                                     input int split_idx, input int split_gap);
        return item_gap + idx * (item_w + item_gap) + ((idx >= split_idx) ? split_gap : 0);
    endfunction

endpackage

// File: rtl/menu_outline_hit.sv
// Combinational test: is (i_x, i_y) on the BORDER-thick outline of a fixed rectangle.
module menu_outline_hit #(
    parameter int LEFT   = 0,
    parameter int TOP    = 0,
    parameter int WIDTH  = 60,
    parameter int HEIGHT = 45,
    parameter int BORDER = 2
) (
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    output logic       o_hit
);

    localparam int RIGHT  = LEFT + WIDTH - 1;
    localparam int BOTTOM = TOP + HEIGHT - 1;

    // 11 bits so right-hand boxes and border offsets never wrap.
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_inside;
    logic        w_edge;

    assign w_x = {1'b0, i_x};
    assign w_y = {1'b0, i_y};

    assign w_inside = (w_x >= 11'(LEFT)) && (w_x <= 11'(RIGHT)) &&
                      (w_y >= 11'(TOP))  && (w_y <= 11'(BOTTOM));

    assign w_edge = (w_x < 11'(LEFT + BORDER)) || (w_x > 11'(RIGHT - BORDER)) ||
                    (w_y < 11'(TOP + BORDER))  || (w_y > 11'(BOTTOM - BORDER));

    assign o_hit = w_inside && w_edge;

endmodule

// File: rtl/menu_bar_nav.sv
// Top-menu bar: cursor navigation FSM with confirm hold, blinking outline of the
// displayed item and a horizontal separator line, rendered one clock behind pix_x/pix_y.
module menu_bar_nav
    import menu_pkg::*;
#(
    parameter int N_ITEMS      = 6,
    parameter int ITEM_W       = 60,
    parameter int ITEM_GAP     = 10,
    parameter int SPLIT_IDX    = 3,
    parameter int SPLIT_GAP    = 210,
    parameter int Y_TOP        = 17,
    parameter int ITEM_H       = 45,
    parameter int BORDER       = 2,
    parameter int SEP_Y        = 80,
    parameter int BLINK_FRAMES = 16,
    parameter int HOLD_FRAMES  = 30,
    localparam int IDXW        = $clog2(N_ITEMS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_tick,
    input  logic            btn_left,
    input  logic            btn_right,
    input  logic            btn_enter,
    input  logic [9:0]      pix_x,
    input  logic [9:0]      pix_y,
    output logic            graph_on,
    output logic [2:0]      graph_rgb,
    output logic [IDXW-1:0] cursor,
    output logic            sel_valid,
    output logic [IDXW-1:0] sel_index
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int BW = $clog2(2 * BLINK_FRAMES);

    state_t          r_state;
    logic [IDXW-1:0] r_cursor;
    logic [IDXW-1:0] r_disp;
    logic [IDXW-1:0] r_sel_index;
    logic            r_sel_valid;
    logic [HW-1:0]   r_hold;
    logic [BW-1:0]   r_blink;
    logic            r_graph_on;
    logic [2:0]      r_graph_rgb;

    logic [N_ITEMS-1:0] w_hit;
    logic               w_sep;
    logic               w_vis;
    logic               w_box;
    logic               w_on;
    logic [2:0]         w_rgb;

    // One outline tester per item; only the displayed one is selected below.
    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_box
        menu_outline_hit #(
            .LEFT  (item_left(gi, ITEM_W, ITEM_GAP, SPLIT_IDX, SPLIT_GAP)),
            .TOP   (Y_TOP),
            .WIDTH (ITEM_W),
            .HEIGHT(ITEM_H),
            .BORDER(BORDER)
        ) u_hit (
            .i_x  (pix_x),
            .i_y  (pix_y),
            .o_hit(w_hit[gi])
        );
    end

    assign w_sep = (pix_y >= 10'(SEP_Y - 2)) && (pix_y <= 10'(SEP_Y));
    assign w_vis = (r_state == ST_CONFIRM) || (r_blink < BW'(BLINK_FRAMES));
    assign w_box = w_hit[r_disp] && w_vis;

    always_comb begin
        w_on  = 1'b0;
        w_rgb = COL_OFF;
        if (w_sep) begin
            w_on  = 1'b1;
            w_rgb = COL_SEP;
        end else if (w_box) begin
            w_on  = 1'b1;
            w_rgb = (r_state == ST_CONFIRM) ? COL_CONFIRM : COL_BROWSE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_BROWSE;
            r_cursor    <= '0;
            r_disp      <= '0;
            r_sel_index <= '0;
            r_sel_valid <= 1'b0;
            r_hold      <= '0;
            r_blink     <= '0;
        end else begin
            r_sel_valid <= 1'b0;
            // Display index and blink phase only change at frame start.
            if (frame_tick) begin
                r_disp  <= r_cursor;
                r_blink <= (r_blink == BW'(2 * BLINK_FRAMES - 1)) ? '0 : r_blink + 1'b1;
            end
            case (r_state)
                ST_BROWSE: begin
                    if (btn_enter) begin
                        r_state     <= ST_CONFIRM;
                        r_sel_valid <= 1'b1;
                        r_sel_index <= r_cursor;
                        r_hold      <= '0;
                    end else if (btn_right && !btn_left) begin
                        r_cursor <= (r_cursor == IDXW'(N_ITEMS - 1)) ? '0 : r_cursor + 1'b1;
                    end else if (btn_left && !btn_right) begin
                        r_cursor <= (r_cursor == '0) ? IDXW'(N_ITEMS - 1) : r_cursor - 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (frame_tick) begin
                        if (r_hold == HW'(HOLD_FRAMES - 1)) begin
                            r_state <= ST_BROWSE;
                            r_hold  <= '0;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_BROWSE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_graph_on  <= 1'b0;
            r_graph_rgb <= COL_OFF;
        end else begin
            r_graph_on  <= w_on;
            r_graph_rgb <= w_rgb;
        end
    end

    assign graph_on  = r_graph_on;
    assign graph_rgb = r_graph_rgb;
    assign cursor    = r_cursor;
    assign sel_valid = r_sel_valid;
    assign sel_index = r_sel_index;

endmodule

// File: tb/tb_menu_bar_nav.sv
// Scoreboard bench for menu_bar_nav: directed scenarios then random traffic against a reference model.
module tb_menu_bar_nav;

    localparam int N    = 6;
    localparam int IW   = 60;
    localparam int IG   = 10;
    localparam int SI   = 3;
    localparam int SG   = 210;
    localparam int YT   = 17;
    localparam int IH   = 45;
    localparam int BD   = 2;
    localparam int SEPY = 80;
    localparam int BF   = 16;
    localparam int HF   = 30;
    localparam int IDXW = $clog2(N);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            frame_tick = 1'b0;
    logic            btn_left = 1'b0;
    logic            btn_right = 1'b0;
    logic            btn_enter = 1'b0;
    logic [9:0]      pix_x = '0;
    logic [9:0]      pix_y = '0;
    logic            graph_on;
    logic [2:0]      graph_rgb;
    logic [IDXW-1:0] cursor;
    logic            sel_valid;
    logic [IDXW-1:0] sel_index;

    always #5 clk = ~clk;

    menu_bar_nav dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_enter (btn_enter),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .graph_on  (graph_on),
        .graph_rgb (graph_rgb),
        .cursor    (cursor),
        .sel_valid (sel_valid),
        .sel_index (sel_index)
    );

    typedef struct {
        int       cyc;
        bit       on;
        bit [2:0] rgb;
        int       cur;
        bit       sv;
        int       si;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int   cyc  = 0;
    int   nvec = 0;
    int   nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: abstract menu state as plain integers.
    int m_cur, m_disp, m_blink, m_hold, m_si;
    bit m_conf;

    function automatic void model_reset();
        m_cur = 0; m_disp = 0; m_blink = 0; m_hold = 0; m_si = 0; m_conf = 0;
    endfunction

    function automatic int left_of(input int i);
        return IG + i * (IW + IG) + ((i >= SI) ? SG : 0);
    endfunction

    function automatic bit on_outline(input int i, input int x, input int y);
        int l;
        l = left_of(i);
        if (x < l || x > l + IW - 1 || y < YT || y > YT + IH - 1) return 1'b0;
        return (x - l < BD) || (l + IW - 1 - x < BD) || (y - YT < BD) || (YT + IH - 1 - y < BD);
    endfunction

    task automatic step(input bit rn, input bit l, input bit r, input bit e, input bit ft,
                        input int x, input int y);
        exp_t ex;
        bit   sep, vis, hit;
        @(posedge clk);
        #1;
        reset = rn; btn_left = l; btn_right = r; btn_enter = e; frame_tick = ft;
        pix_x = 10'(x); pix_y = 10'(y);
        ex.cyc = cyc + 1;
        if (!rn) begin
            model_reset();
            ex.on = 0; ex.rgb = 3'b000; ex.cur = 0; ex.sv = 0; ex.si = 0;
        end else begin
            sep = (y >= SEPY - 2) && (y <= SEPY);
            vis = m_conf || (m_blink < BF);
            hit = on_outline(m_disp, x, y) && vis;
            ex.on  = sep || hit;
            ex.rgb = sep ? 3'b000 : (hit ? (m_conf ? 3'b010 : 3'b100) : 3'b000);
            ex.sv  = 0;
            if (ft) begin
                m_disp  = m_cur;
                m_blink = (m_blink + 1) % (2 * BF);
            end
            if (!m_conf) begin
                if (e) begin
                    m_conf = 1; m_hold = 0; m_si = m_cur; ex.sv = 1;
                end else if (l && !r) begin
                    m_cur = (m_cur + N - 1) % N;
                end else if (r && !l) begin
                    m_cur = (m_cur + 1) % N;
                end
            end else if (ft) begin
                m_hold++;
                if (m_hold == HF) begin
                    m_conf = 0; m_hold = 0;
                end
            end
            ex.cur = m_cur;
            ex.si  = m_si;
        end
        q.push_back(ex);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset landing between clock edges: the pending expectation now reads zero.
    task automatic pulse_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        if (q.size() > 0) begin
            q[q.size()-1].on  = 0;
            q[q.size()-1].rgb = 3'b000;
            q[q.size()-1].cur = 0;
            q[q.size()-1].sv  = 0;
            q[q.size()-1].si  = 0;
        end
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            mx = q.pop_front();
            nvec++;
            if (graph_on !== mx.on) begin
                nerr++; $display("FAIL graph_on cyc=%0d got=%b exp=%b", cyc, graph_on, mx.on);
            end
            if (graph_rgb !== mx.rgb) begin
                nerr++; $display("FAIL graph_rgb cyc=%0d got=%b exp=%b", cyc, graph_rgb, mx.rgb);
            end
            if ($isunknown(cursor) || int'(cursor) != mx.cur) begin
                nerr++; $display("FAIL cursor cyc=%0d got=%0d exp=%0d", cyc, cursor, mx.cur);
            end
            if (sel_valid !== mx.sv) begin
                nerr++; $display("FAIL sel_valid cyc=%0d got=%b exp=%b", cyc, sel_valid, mx.sv);
            end
            if ($isunknown(sel_index) || int'(sel_index) != mx.si) begin
                nerr++; $display("FAIL sel_index cyc=%0d got=%0d exp=%0d", cyc, sel_index, mx.si);
            end
        end
    end

    initial begin
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Right wraps 1..5,0; left from 0 wraps to 5; left+right together holds.
        for (int k = 0; k < N; k++) begin
            step(1, 0, 1, 0, 0, 0, 0);
            idle(1);
        end
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0, 0, 0);

        // Latch cursor 3 as displayed, then sweep the top outline row and the separator.
        step(1, 0, 0, 0, 1, 0, 0);
        for (int x = left_of(3) - 1; x <= left_of(3) + IW + 10; x++) step(1, 0, 0, 0, 0, x, YT);
        for (int x = left_of(3) - 1; x <= left_of(3) + 3; x++) step(1, 0, 0, 0, 0, x, YT + 10);
        for (int k = 0; k < 8; k++) step(1, 0, 0, 0, 0, $urandom_range(0, 639), SEPY - 1);
        step(1, 0, 0, 0, 0, 100, SEPY - 3);
        step(1, 0, 0, 0, 0, 100, SEPY + 1);

        // Confirm item 3 with enter colliding with right; buttons ignored through the hold.
        step(1, 0, 1, 1, 0, 0, 0);
        for (int k = 0; k < HF; k++) begin
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1, left_of(3) + $urandom_range(0, IW - 1), YT);
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 0, left_of(3), YT + $urandom_range(0, IH - 1));
        end
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);

        // Abort a confirm with reset, then a left press must wrap from a fresh cursor 0.
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, left_of(3), YT);
        pulse_reset();
        idle(1);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);

        for (int k = 0; k < 4000; k++) begin
            step(1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 23) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 639),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(10, 90) : $urandom_range(0, 479));
            if (k == 2000) pulse_reset();
        end

        idle(1);
        repeat (4) @(posedge clk);
        if (q.size() != 0) begin
            nerr++; $display("FAIL drain pending=%0d exp=0", q.size());
        end
        if (nvec < 12) begin
            nerr++; $display("FAIL vector_count got=%0d exp>=12", nvec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
